// File: rtl/peripheral_apb4_pkg.sv
// Shared definitions for the APB4 master BFM engine.
// Holds response codes, the transfer state type and the packed command
// layout {write, prot, strb, wdata, addr} used by the command queue.
package peripheral_apb4_pkg;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Width of one queued command for a given address/data width.
  function automatic int cmd_width(input int addr_w, input int data_w);
    return 1 + 3 + data_w / 8 + data_w + addr_w;
  endfunction

endpackage

// File: rtl/peripheral_bfm_fifo_apb4.sv
// Synchronous FIFO holding queued APB commands; head data is read combinationally.
// Ports: push/push_data write, pop advances the head, full/empty status, head_data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module peripheral_bfm_fifo_apb4 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/peripheral_bfm_master_apb4_cmd.sv
// APB4 master engine: queues commands, runs SETUP/ACCESS transfers, returns one response each.
// Ports: cmd_* command in (valid/ready), rsp_* response out (valid/ready), p* APB4 master, busy.
// Wait states honoured via pready; optional TIMEOUT aborts a stuck ACCESS with code 10.
module peripheral_bfm_master_apb4_cmd
  import peripheral_apb4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    busy
);

  localparam int CMD_W  = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  apb_state_t state;

  logic [CMD_W-1:0]      cmd_in;
  logic [CMD_W-1:0]      head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  h_write;
  logic [2:0]            h_prot;
  logic [STRB_W-1:0]     h_strb;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  timeout_hit;

  assign cmd_in = {cmd_write, cmd_prot, cmd_strb, cmd_wdata, cmd_addr};
  assign {h_write, h_prot, h_strb, h_wdata, h_addr} = head;

  peripheral_bfm_fifo_apb4 #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head)
  );

  assign cmd_ready = !fifo_full;

  // Only start a transfer if its response will have somewhere to land.
  assign fifo_pop = (state == IDLE) && !fifo_empty && (!rsp_valid || rsp_ready);

  // The wait counter only advances in ACCESS, so this is meaningless elsewhere.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  assign busy = !fifo_empty || (state != IDLE) || rsp_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      paddr     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OKAY;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            paddr   <= h_addr;
            pwrite  <= h_write;
            pwdata  <= h_wdata;
            pprot   <= h_prot;
            pstrb   <= h_write ? h_strb : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout expiring on the same cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pstrb     <= '0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr ? RSP_SLVERR : RSP_OKAY;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timeout_hit) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pstrb     <= '0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= RSP_TIMEOUT;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bfm_master_apb4_cmd.sv
// Bench for the APB4 master engine: directed command sequences against a
// queue-based transaction model, plus literal checks on key transfers.
module tb_peripheral_bfm_master_apb4_cmd;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata = '0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        busy;

  always #5 aclk = ~aclk;

  peripheral_bfm_master_apb4_cmd #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CMD_DEPTH  (4),
    .TIMEOUT    (16)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .busy      (busy)
  );

  typedef struct packed {
    logic        write;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // fifo_q: accepted commands not yet started; cur: transfer on the bus;
  // rsp_q: responses owed to the response port.
  cmd_t fifo_q[$];
  rsp_t rsp_q[$];
  cmd_t cur;
  int   phase = 0;      // 0 no transfer, 1 setup cycle, 2 access cycle
  int   acc_cycles = 0; // access cycles already spent without pready

  int          acc_run = 0;
  int          last_acc_len = 0;
  logic [31:0] last_rsp_rdata = '0;
  logic [1:0]  last_rsp_err = '0;

  always @(negedge aclk) begin
    bit   slot_free;
    bit   can_push;
    cmd_t nc;

    if (!aresetn) begin
      fifo_q.delete();
      rsp_q.delete();
      phase = 0;
      acc_cycles = 0;
    end

    // Outputs expected for the cycle now in progress.
    chk("cmd_ready", cmd_ready, fifo_q.size() < 4);
    chk("busy", busy, (fifo_q.size() != 0) || (phase != 0) || (rsp_q.size() != 0));
    chk("psel", psel, phase != 0);
    chk("penable", penable, phase == 2);
    if (phase != 0) begin
      chk("paddr", paddr, cur.addr);
      chk("pwrite", pwrite, cur.write);
      chk("pwdata", pwdata, cur.wdata);
      chk("pprot", pprot, cur.prot);
      chk("pstrb", pstrb, cur.write ? cur.strb : 4'h0);
    end else begin
      chk("pstrb_idle", pstrb, 4'h0);
    end
    chk("rsp_valid", rsp_valid, rsp_q.size() != 0);
    if (rsp_q.size() != 0) begin
      chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
      chk("rsp_err", rsp_err, rsp_q[0].err);
    end

    // Bookkeeping for literal checks.
    if (penable) acc_run++;
    else if (acc_run != 0) begin
      last_acc_len = acc_run;
      acc_run = 0;
    end
    if (rsp_valid && rsp_ready) begin
      last_rsp_rdata = rsp_rdata;
      last_rsp_err   = rsp_err;
    end

    // Advance the model across the coming rising edge.
    if (aresetn) begin
      slot_free = (rsp_q.size() == 0) || rsp_ready;
      can_push  = cmd_valid && (fifo_q.size() < 4);
      nc = '{write: cmd_write, prot: cmd_prot, strb: cmd_strb, wdata: cmd_wdata, addr: cmd_addr};
      if (rsp_q.size() != 0 && rsp_ready) void'(rsp_q.pop_front());
      case (phase)
        0: if (fifo_q.size() != 0 && slot_free) begin
             cur = fifo_q.pop_front();
             phase = 1;
           end
        1: begin
             phase = 2;
             acc_cycles = 0;
           end
        default: begin
          acc_cycles++;
          if (pready) begin
            rsp_q.push_back('{rdata: cur.write ? 32'h0 : prdata, err: pslverr ? 2'b01 : 2'b00});
            phase = 0;
          end else if (acc_cycles == 16) begin
            rsp_q.push_back('{rdata: 32'h0, err: 2'b10});
            phase = 0;
          end
        end
      endcase
      if (can_push) fifo_q.push_back(nc);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drive tasks start and end 1ns after a rising edge.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    bit ok = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("push_accepted", ok, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (!busy) begin ok = 1; break; end
    end
    chk("wait_idle", ok, 1'b1);
    @(posedge aclk); #1;
  endtask

  // Returns at the falling edge of the first ACCESS cycle.
  task automatic wait_access();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (psel && penable) begin ok = 1; break; end
    end
    chk("wait_access", ok, 1'b1);
  endtask

  task automatic clr_last();
    last_rsp_rdata = 32'hFFFF_FFFF;
    last_rsp_err   = 2'b11;
    last_acc_len   = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Reset state
    #3;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_pprot", pprot, 3'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_busy", busy, 1'b0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge aclk); #1;

    // Single write, zero wait states
    clr_last();
    push(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3'b000);
    @(negedge aclk);
    @(negedge aclk);
    chk("wr_setup_psel", psel, 1'b1);
    chk("wr_setup_penable", penable, 1'b0);
    chk("wr_setup_pstrb", pstrb, 4'hF);
    @(negedge aclk);
    chk("wr_access_penable", penable, 1'b1);
    chk("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
    @(posedge aclk); #1;
    wait_idle();
    chk("wr_rsp_err", last_rsp_err, 2'b00);
    chk("wr_rsp_rdata", last_rsp_rdata, 32'h0);
    chk("wr_acc_len", last_acc_len, 1);

    // Read with three wait states
    clr_last();
    pready = 1'b0;
    push(1'b0, 32'h44, 32'h0, 4'hF, 3'b010);
    wait_access();
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    pready = 1'b1; prdata = 32'h1234_5678;
    @(posedge aclk); #1;
    pready = 1'b0; prdata = 32'h0;
    wait_idle();
    chk("rd_acc_len", last_acc_len, 4);
    chk("rd_rsp_rdata", last_rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", last_rsp_err, 2'b00);

    // PSLVERR with response held, then fill the FIFO behind it
    pready = 1'b1; pslverr = 1'b1; rsp_ready = 1'b0;
    push(1'b1, 32'h80, 32'hCAFE_F00D, 4'h3, 3'b001);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("slv_rsp_seen", ok, 1'b1);
    chk("slv_rsp_err", rsp_err, 2'b01);
    chk("slv_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge aclk); #1;
    pslverr = 1'b0;
    prdata = 32'hA5A5_0001;
    push(1'b0, 32'h200, 32'h0, 4'hF, 3'b001);
    push(1'b1, 32'h204, 32'h1111_2222, 4'h5, 3'b010);
    push(1'b0, 32'h208, 32'h0, 4'h0, 3'b011);
    push(1'b1, 32'h20C, 32'h3333_4444, 4'hF, 3'b100);
    @(negedge aclk);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_psel_blocked", psel, 1'b0);
    @(posedge aclk); #1;
    cmd_write = 1'b0; cmd_addr = 32'h210; cmd_wdata = 32'h0; cmd_strb = 4'hF; cmd_prot = 3'b101;
    cmd_valid = 1'b1;
    repeat (6) @(negedge aclk);
    chk("held_rsp_valid", rsp_valid, 1'b1);
    chk("held_rsp_err", rsp_err, 2'b01);
    chk("held_psel", psel, 1'b0);
    @(posedge aclk); #1;
    rsp_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("fifth_accepted", ok, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    clr_last();
    wait_idle();
    chk("drain_last_rdata", last_rsp_rdata, 32'hA5A5_0001);
    chk("drain_last_err", last_rsp_err, 2'b00);
    prdata = 32'h0;

    // Timeout with pready stuck low
    clr_last();
    pready = 1'b0;
    push(1'b0, 32'h300, 32'h0, 4'hF, 3'b000);
    wait_idle();
    chk("to_acc_len", last_acc_len, 16);
    chk("to_rsp_err", last_rsp_err, 2'b10);
    chk("to_rsp_rdata", last_rsp_rdata, 32'h0);

    // pready on the final allowed ACCESS cycle wins over the timeout
    clr_last();
    push(1'b0, 32'h304, 32'h0, 4'hF, 3'b000);
    wait_access();
    repeat (15) @(posedge aclk);
    #1;
    pready = 1'b1; prdata = 32'hBEEF_0016;
    @(posedge aclk); #1;
    pready = 1'b0; prdata = 32'h0;
    wait_idle();
    chk("edge_acc_len", last_acc_len, 16);
    chk("edge_rsp_err", last_rsp_err, 2'b00);
    chk("edge_rsp_rdata", last_rsp_rdata, 32'hBEEF_0016);

    // Reset asserted during ACCESS
    clr_last();
    push(1'b1, 32'h400, 32'h5555_AAAA, 4'hF, 3'b000);
    wait_access();
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_psel", psel, 1'b0);
    chk("arst_penable", penable, 1'b0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    pready = 1'b1;
    repeat (5) @(negedge aclk);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_no_rsp", last_rsp_err, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
